// File: rtl/cdma_pkg.sv
// cdma_pkg: shared state type and constants for the CDMA sequencer.
//   state_t      - sequencer FSM states
//   SEED_W       - Gold seed width
//   DEFAULT_SEED - substitute for an all-zero seed (avoids LFSR lock-up)
//   PRE_START    - value of the first preamble bit
package cdma_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PRE, DATA, GAP} state_t;
  localparam int SEED_W = 4;
  localparam logic [SEED_W-1:0] DEFAULT_SEED = 4'b0001;
  localparam logic PRE_START = 1'b1;
endpackage

// File: rtl/cdma_chip_timer.sv
// cdma_chip_timer: chip-rate prescaler and chip counter.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_run          - count enable; counters are cleared while low
//   o_tick         - one-cycle chip strobe (prescaler at CHIP_DIV-1)
//   o_epoch        - tick on chip 0 of a code period
//   o_boundary     - tick on the last chip of a code period
module cdma_chip_timer #(
  parameter logic [23:0] CHIP_DIV = 24'd10_000_000,
  parameter int GOLD_LEN = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_tick,
  output logic o_epoch,
  output logic o_boundary
);
  localparam int CW = $clog2(GOLD_LEN);
  logic [23:0]   r_pre;
  logic [CW-1:0] r_chip;
  assign o_tick = i_run && r_pre == CHIP_DIV - 24'd1;
  assign o_epoch = o_tick && r_chip == '0;
  assign o_boundary = o_tick && r_chip == CW'(GOLD_LEN - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pre <= '0;
      r_chip <= '0;
    end else if (!i_run) begin
      r_pre <= '0;
      r_chip <= '0;
    end else if (o_tick) begin
      r_pre <= '0;
      r_chip <= o_boundary ? '0 : r_chip + CW'(1);
    end else begin
      r_pre <= r_pre + 24'd1;
    end
endmodule

// File: rtl/cdma_seq_ctrl.sv
// cdma_seq_ctrl: Gold-code CDMA spreader sequencer (preamble + payload framing).
//   clk_i, set_i       - clock, asynchronous active-low reset
//   start_i, seed_i    - frame request (level) and Gold seed
//   data_i, data_valid_i, data_ready_o - one-entry payload bit buffer
//   seed_load_o, seed_o - seed load pulse and registered seed
//   chip_en_o, epoch_o  - chip strobe and code-period start strobe
//   bit_o               - current data bit to spread
//   busy_o, underrun_o, LED_o - status
// Optional: define CDMA_SEQ_ABORT_EN to add abort_i (return to IDLE at once).
module cdma_seq_ctrl import cdma_pkg::*; #(
  parameter logic [23:0] CHIP_DIV = 24'd10_000_000,
  parameter int GOLD_LEN = 15,
  parameter int PRE_BITS = 4,
  parameter int FRAME_BITS = 8,
  parameter int GAP_CHIPS = 15
) (
  input  logic              clk_i,
  input  logic              set_i,
  input  logic              start_i,
  input  logic [SEED_W-1:0] seed_i,
  input  logic              data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic              seed_load_o,
  output logic [SEED_W-1:0] seed_o,
  output logic              chip_en_o,
  output logic              epoch_o,
  output logic              bit_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              LED_o
`ifdef CDMA_SEQ_ABORT_EN
  ,
  input  logic              abort_i
`endif
);
  localparam int M1 = PRE_BITS > FRAME_BITS ? PRE_BITS : FRAME_BITS;
  localparam int MX = M1 > GAP_CHIPS ? M1 : GAP_CHIPS;
  localparam int CW = $clog2(MX + 1);
  state_t r_state, w_nxt;
  logic [SEED_W-1:0] r_seed;
  logic [CW-1:0] r_cnt;
  logic r_bit, r_led, r_und, r_buf, r_full, r_rdy;
  logic w_tick, w_epoch, w_bnd, w_run, w_abort, w_chip_en;
  logic w_pre_end, w_data_end, w_gap_end, w_pop, w_wr, w_full_nxt, w_seed_cap;
`ifdef CDMA_SEQ_ABORT_EN
  assign w_abort = abort_i && r_state != IDLE;
`else
  assign w_abort = 1'b0;
`endif
  assign w_run = r_state == PRE || r_state == DATA || r_state == GAP;
  cdma_chip_timer #(.CHIP_DIV(CHIP_DIV), .GOLD_LEN(GOLD_LEN)) u_timer (
    .i_clk(clk_i), .i_rst_n(set_i), .i_run(w_run),
    .o_tick(w_tick), .o_epoch(w_epoch), .o_boundary(w_bnd)
  );
  assign w_pre_end = r_state == PRE && w_bnd && r_cnt == CW'(PRE_BITS - 1);
  assign w_data_end = r_state == DATA && w_bnd && r_cnt == CW'(FRAME_BITS - 1);
  assign w_gap_end = r_state == GAP && w_tick && r_cnt == CW'(GAP_CHIPS - 1);
  // Payload pops at the preamble/payload boundary and at every payload boundary but the last.
  assign w_pop = w_pre_end || (r_state == DATA && w_bnd && !w_data_end);
  assign w_wr = data_valid_i && data_ready_o;
  // The pop consumes the old content, so a write in the same cycle is kept.
  assign w_full_nxt = !w_abort && (w_wr || (r_full && !w_pop));
  assign w_seed_cap = start_i && (r_state == IDLE || w_gap_end) && !w_abort;
  assign w_chip_en = w_tick && (r_state == PRE || r_state == DATA) && !w_abort;
  assign chip_en_o = w_chip_en;
  assign epoch_o = w_chip_en && w_epoch;
  assign seed_load_o = r_state == LOAD && !w_abort;
  assign seed_o = r_seed;
  assign bit_o = r_bit && !w_abort;
  assign busy_o = r_state != IDLE;
  assign underrun_o = r_und;
  assign LED_o = r_led;
  // r_rdy is held low by reset so data_ready_o rises on the first clock after it.
  assign data_ready_o = r_rdy && r_state != LOAD;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: w_nxt = start_i ? LOAD : IDLE;
      LOAD: w_nxt = PRE;
      PRE:  w_nxt = w_pre_end ? DATA : PRE;
      DATA: w_nxt = w_data_end ? GAP : DATA;
      GAP:  w_nxt = w_gap_end ? (start_i ? LOAD : IDLE) : GAP;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end
  always_ff @(posedge clk_i or negedge set_i)
    if (!set_i) begin
      r_state <= IDLE;
      r_seed <= '0;
      r_cnt <= '0;
      r_bit <= 1'b0;
      r_led <= 1'b0;
      r_und <= 1'b0;
      r_buf <= 1'b0;
      r_full <= 1'b0;
      r_rdy <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_full <= w_full_nxt;
      r_rdy <= !w_full_nxt;
      if (w_wr) r_buf <= data_i;
      if (w_seed_cap) r_seed <= seed_i == '0 ? DEFAULT_SEED : seed_i;
      if (r_state == LOAD && !w_abort) r_und <= 1'b0;
      else if (w_pop && !r_full && !w_abort) r_und <= 1'b1;
      if (w_data_end && !w_abort) r_led <= ~r_led;
      if (w_abort) r_bit <= 1'b0;
      else if (r_state == LOAD) r_bit <= PRE_START;
      else if (w_pop) r_bit <= r_full && r_buf;
      else if (r_state == PRE && w_bnd) r_bit <= ~r_bit;
      else if (w_data_end) r_bit <= 1'b0;
      // r_cnt counts preamble bits, payload bits, then gap chips.
      if (r_state == LOAD || w_pre_end || w_data_end || w_gap_end) r_cnt <= '0;
      else if (((r_state == PRE || r_state == DATA) && w_bnd) || (r_state == GAP && w_tick))
        r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: tb/tb_cdma_seq_ctrl.sv
// tb_cdma_seq_ctrl: scoreboard bench for cdma_seq_ctrl with CHIP_DIV=4.
module tb_cdma_seq_ctrl;
  logic clk_i = 1'b0;
  logic set_i, start_i, data_i, data_valid_i;
  logic [3:0] seed_i, seed_o;
  logic data_ready_o, seed_load_o, chip_en_o, epoch_o, bit_o, busy_o, underrun_o, LED_o;
  int errors = 0, checks = 0, n_chip = 0, n_epoch = 0;
  logic [1:0] exp_bit[$];
  logic [3:0] exp_seed[$];
  logic src_q[$];
  logic acc = 1'b0;

  cdma_seq_ctrl #(.CHIP_DIV(24'd4), .GOLD_LEN(15), .PRE_BITS(4), .FRAME_BITS(8), .GAP_CHIPS(15)) dut (
    .clk_i(clk_i), .set_i(set_i), .start_i(start_i), .seed_i(seed_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .seed_load_o(seed_load_o),
    .seed_o(seed_o), .chip_en_o(chip_en_o), .epoch_o(epoch_o), .bit_o(bit_o),
    .busy_o(busy_o), .underrun_o(underrun_o), .LED_o(LED_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // w: 0 seed_load_o, 1 chip_en_o, 2 !busy_o, 3 epoch_o; returns cycles to the k-th hit
  task automatic wait_cond(input int w, input int k, input int lim, output int n);
    int hits;
    hits = 0;
    n = 0;
    while (hits < k && n < lim) begin
      @(negedge clk_i);
      n++;
      if ((w == 0 && seed_load_o) || (w == 1 && chip_en_o) || (w == 2 && !busy_o) || (w == 3 && epoch_o))
        hits++;
    end
    if (hits < k) begin
      errors++;
      checks++;
      $display("FAIL timeout cond=%0d: got %0d hits expected %0d", w, hits, k);
    end
  endtask

  task automatic push_src(input logic [7:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) src_q.push_back(v[i]);
  endtask

  // Preamble 1,0,1,0 then payload LSB first; und marks bits at which underrun_o is expected set.
  task automatic push_frame(input logic [7:0] pay, input logic [7:0] und);
    for (int i = 0; i < 4; i++) exp_bit.push_back({~i[0], 1'b0});
    for (int i = 0; i < 8; i++) exp_bit.push_back({pay[i], und[i]});
  endtask

  // Payload source: a transfer happens at the posedge after a negedge where valid & ready.
  initial begin
    data_valid_i = 1'b0;
    data_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      data_valid_i = src_q.size() > 0;
      data_i = data_valid_i ? src_q[0] : 1'b0;
      acc = data_valid_i && data_ready_o;
    end
  end

  // Monitor: compares seed at each seed load and {bit, underrun} at each epoch.
  always @(negedge clk_i) if (set_i) begin
    if (chip_en_o) n_chip++;
    if (epoch_o) n_epoch++;
    if (seed_load_o) begin
      if (exp_seed.size() == 0) begin
        errors++; checks++;
        $display("FAIL seed_unexpected: got seed load %0h expected none", seed_o);
      end else chk("seed", seed_o, exp_seed.pop_front());
    end
    if (epoch_o) begin
      if (exp_bit.size() == 0) begin
        errors++; checks++;
        $display("FAIL bit_unexpected: got epoch bit %0b expected none", bit_o);
      end else chk("bit_und", {bit_o, underrun_o}, exp_bit.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, e0;
    set_i = 1'b0; start_i = 1'b0; seed_i = 4'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_outs", {data_ready_o, seed_load_o, seed_o, chip_en_o, epoch_o, bit_o, busy_o, underrun_o, LED_o}, 0);
    set_i = 1'b1;
    @(negedge clk_i);
    chk("rdy_after_rst", data_ready_o, 1);
    // Frame 1: seed A, payload 1100_1010
    push_src(8'b1100_1010, 0, 7);
    push_frame(8'b1100_1010, 8'h00);
    exp_seed.push_back(4'hA);
    repeat (2) @(negedge clk_i);
    chk("rdy_full", data_ready_o, 0);
    c0 = n_chip; e0 = n_epoch;
    seed_i = 4'hA; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("seed_load1", seed_load_o, 1);
    wait_cond(1, 1, 20, n);
    chk("first_chip", n, 4);
    wait_cond(2, 1, 2000, n);
    chk("busy_len", n, 777);
    chk("chips", n_chip - c0, 180);
    chk("epochs", n_epoch - e0, 12);
    chk("led1", LED_o, 1);
    chk("und1", underrun_o, 0);
    chk("q_empty1", exp_bit.size(), 0);
    // Frame 2: zero seed, source stalls before payload bit 3
    push_src(8'b0110_1101, 0, 2);
    push_frame(8'b0110_0101, 8'b1111_1000);
    exp_seed.push_back(4'h1);
    repeat (3) @(negedge clk_i);
    seed_i = 4'h0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_cond(3, 8, 1000, n);
    push_src(8'b0110_1101, 4, 7);
    wait_cond(2, 1, 2000, n);
    chk("und_idle", underrun_o, 1);
    chk("led2", LED_o, 0);
    chk("q_empty2", exp_bit.size(), 0);
    // Frames 3 and 4: continuous mode, seed changes 3 -> 5
    push_src(8'b1010_0101, 0, 7);
    push_src(8'b0011_1100, 0, 7);
    push_frame(8'b1010_0101, 8'h00);
    push_frame(8'b0011_1100, 8'h00);
    exp_seed.push_back(4'h3);
    exp_seed.push_back(4'h5);
    repeat (3) @(negedge clk_i);
    seed_i = 4'h3; start_i = 1'b1;
    @(negedge clk_i);
    chk("und_in_load", underrun_o, 1);
    @(negedge clk_i);
    chk("und_cleared", underrun_o, 0);
    seed_i = 4'h5;
    wait_cond(0, 1, 2000, n);
    chk("gap_restart", n, 780);
    start_i = 1'b0;
    wait_cond(3, 6, 1000, n);
    chk("rdy_full_data", data_ready_o, 0);
    // Asynchronous reset mid-DATA
    #2 set_i = 1'b0;
    #1 chk("async_rst", {data_ready_o, seed_load_o, seed_o, chip_en_o, epoch_o, bit_o, busy_o, underrun_o, LED_o}, 0);
    exp_bit.delete();
    src_q.delete();
    acc = 1'b0;
    chk("seed_q_empty", exp_seed.size(), 0);
    repeat (2) @(negedge clk_i);
    set_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("idle_after_rst", {busy_o, data_ready_o}, 2'b01);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
